stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Run/pause/clear control front end for the stopwatch datapath. It conditions the two push buttons and runs the stopwatch state machine. It divides the system clock into the one-cycle count-enable pulse that drives the digit counter chain, and issues a synchronous clear to that chain. It sits directly upstream of the eight-digit BCD counter chain and, when lap is compiled in, also between that chain's 32-bit output and the display.

## Interface
- TICK_DIV, 100000: system-clock cycles per count-enable pulse; legal range ≥ 2.
- DEB_CYCLES, 500000: consecutive stable synchronised samples required to accept a button level; legal range ≥ 2.
- clk  in  1: system clock; all logic on rising edge.
- reset  in  1: asynchronous, active-low reset.
- btn_run  in  1: raw run/pause button, active-high, asynchronous to clk.
- btn_clear  in  1: raw clear button, active-high, asynchronous.
- btn_lap  in  1: raw lap button. Present only with STOPWATCH_LAP_EN.
- cnt_data  in  32: BCD time from the counter chain. Present only with STOPWATCH_LAP_EN.
- tc_cnt  out  1: one-cycle count-enable pulse to the counter chain.
- cnt_clear  out  1: one-cycle synchronous clear to the counter chain.
- running  out  1: high while in RUN.
- disp_data  out  32: data to the display. Present only with STOPWATCH_LAP_EN.

## Operation
- Button path, applied per button:
  - 2-flop synchroniser.
  - Debounce counter resets on every change of the synchronised level. When it reaches DEB_CYCLES-1 with the level unchanged, the debounced level is updated.
  - A rising edge of the debounced level produces a one-cycle press pulse. Release produces nothing.
- FSM states are IDLE, RUN, PAUSE and CLEAR. Transitions:
  - IDLE + run press → RUN.
  - RUN + run press → PAUSE. A clear press in RUN is ignored.
  - PAUSE + clear press → CLEAR. If run and clear press in the same cycle in PAUSE, clear wins.
  - PAUSE + run press → RUN.
  - CLEAR → IDLE unconditionally after one cycle. A run press arriving while in CLEAR is dropped.
  - IDLE + clear press → CLEAR, so a spurious count can still be cleared.
- Prescaler, counting 0..TICK_DIV-1:
  - Increments only in RUN.
  - Holds its value in PAUSE, so resume keeps sub-tick phase.
  - Forced to 0 in CLEAR and IDLE.
  - When it reaches TICK_DIV-1 in RUN it wraps to 0 and asserts tc_cnt for exactly one cycle.
  - If a run press lands in the same cycle as the wrap, tc_cnt is still issued and the prescaler holds at 0 in PAUSE.
- cnt_clear is asserted for exactly the one cycle the FSM is in CLEAR. tc_cnt is never high in that cycle.
- running = (state == RUN).

## Timing
- All outputs are registered.
- Reset values: state IDLE, prescaler 0, debounce counters 0, debounced levels 0, tc_cnt 0, cnt_clear 0, running 0, lap_hold 0, lap register 0.
- Reset is asynchronous on assertion. Release takes effect on the next clk edge. Reset mid-count abandons all state immediately.
- Button latency: a clean edge held stable at the pin produces its press pulse 2 (sync) + DEB_CYCLES cycles later. The FSM changes state on the following edge, and running follows in the same cycle as the state.
- tc_cnt period in continuous RUN is exactly TICK_DIV cycles. The first pulse arrives TICK_DIV cycles after entering RUN from IDLE.
- Glitches shorter than DEB_CYCLES cycles produce no pulse.

## Configuration
- STOPWATCH_LAP_EN defined:
  - Adds btn_lap, cnt_data and disp_data, plus a third debouncer and a lap_hold flag.
  - A lap press in RUN or PAUSE toggles lap_hold. Toggling lap_hold to 1 captures cnt_data into the lap register on the same edge.
  - disp_data = lap_hold ? lap register : cnt_data, registered with one cycle of latency.
  - CLEAR forces lap_hold to 0. A lap press in IDLE or CLEAR is ignored.
- STOPWATCH_LAP_EN undefined: those ports and that logic are absent. Counting behaviour is identical.

## Structure
- Shared package stopwatch_pkg holds:
  - the FSM state type (IDLE, RUN, PAUSE, CLEAR, 2-bit encoding);
  - the default TICK_DIV and DEB_CYCLES constants.
- Sub-module btn_debounce (synchroniser, debounce counter, edge pulse), parameterised by DEB_CYCLES and instantiated once per button.
- The FSM, prescaler and lap logic live in stopwatch_ctrl.

## Test plan
- Bench parameters: TICK_DIV=4, DEB_CYCLES=3.
- Reset then clean run press → press pulse 5 cycles after the edge; running=1 on the next edge; tc_cnt high every 4th cycle, first pulse 4 cycles after entering RUN.
- Glitch of 2 cycles on btn_run → no press pulse; state stays IDLE.
- RUN, pause with the prescaler at 2, resume → first tc_cnt after resume arrives 2 cycles after re-entering RUN.
- PAUSE with simultaneous run and clear presses → CLEAR for one cycle with cnt_clear=1 and tc_cnt=0, then IDLE with running=0.
- Clear press in RUN → ignored; tc_cnt cadence unchanged.
- With STOPWATCH_LAP_EN: cnt_data=32'h0012_3456, lap press → disp_data frozen at 32'h0012_3456 while cnt_data changes; second lap press → disp_data tracks cnt_data again. Reset asserted mid-RUN → all outputs 0 immediately.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and default timing constants for the stopwatch control front end.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    CLEAR = 2'd3
  } sw_state_t;

  localparam int unsigned TICK_DIV_DEF   = 100000;
  localparam int unsigned DEB_CYCLES_DEF = 500000;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, and a one-cycle
// press pulse on each accepted rising level.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // cnt counts consecutive samples disagreeing with the accepted level;
  // any agreeing sample (i.e. a change back) restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/clear FSM, count-enable prescaler and optional lap hold.
// Lap hold and its ports are compiled in with STOPWATCH_LAP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_run,
  input  logic        btn_clear,
`ifdef STOPWATCH_LAP_EN
  input  logic        btn_lap,
  input  logic [31:0] cnt_data,
  output logic [31:0] disp_data,
`endif
  output logic        tc_cnt,
  output logic        cnt_clear,
  output logic        running
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  sw_state_t     state;
  sw_state_t     state_nx;
  logic [PW-1:0] presc;
  logic          run_press;
  logic          clear_press;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_run),
    .press (run_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_clear),
    .press (clear_press)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (clear_press)    state_nx = CLEAR;
        else if (run_press) state_nx = RUN;
      end
      RUN: begin
        if (run_press) state_nx = PAUSE;
      end
      PAUSE: begin
        if (clear_press)    state_nx = CLEAR;
        else if (run_press) state_nx = RUN;
      end
      CLEAR:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // running/cnt_clear are registered from the next state so they line up
  // with the state register rather than lagging it by a cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      running   <= 1'b0;
      cnt_clear <= 1'b0;
    end else begin
      state     <= state_nx;
      running   <= (state_nx == RUN);
      cnt_clear <= (state_nx == CLEAR);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc  <= '0;
      tc_cnt <= 1'b0;
    end else begin
      tc_cnt <= 1'b0;
      case (state)
        RUN: begin
          if (presc == PRESC_LAST) begin
            presc  <= '0;
            tc_cnt <= 1'b1;
          end else begin
            presc <= presc + 1'b1;
          end
        end
        PAUSE:   presc <= presc;
        default: presc <= '0;
      endcase
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic        lap_press;
  logic        lap_hold;
  logic [31:0] lap_reg;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_lap),
    .press (lap_press)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lap_hold  <= 1'b0;
      lap_reg   <= '0;
      disp_data <= '0;
    end else begin
      disp_data <= lap_hold ? lap_reg : cnt_data;
      if (state == CLEAR) begin
        lap_hold <= 1'b0;
      end else if (lap_press && (state == RUN || state == PAUSE)) begin
        lap_hold <= !lap_hold;
        if (!lap_hold) lap_reg <= cnt_data;
      end
    end
  end
`endif

endmodule
